// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: funct3 codes, FSM encoding and
// the alignment rule applied at request acceptance.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StAccess  = 2'b01,
    StMergeWr = 2'b10,
    StDone    = 2'b11
  } lsu_state_e;

  // Undefined width codes are rejected the same way as misaligned addresses.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      F3_B, F3_BU: mis = 1'b0;
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational lane logic: load byte/half selection with extension, and the
// byte/half merge that turns a sub-word store into a whole-word write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rd_word,
  input  logic [31:0] merge_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = rd_word[{addr_lo, 3'b000} +: 8];
  assign ld_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = rd_word;
    case (funct3)
      F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   load_data = {24'h000000, ld_byte};
      F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   load_data = {16'h0000, ld_half};
      default: load_data = rd_word;
    endcase
  end

  // funct3[1:0] alone picks the store width; the sign bit has no meaning for stores.
  always_comb begin
    store_data = merge_word;
    case (funct3[1:0])
      2'b00: store_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (addr_lo[1]) store_data[31:16] = wdata[15:0];
        else            store_data[15:0]  = wdata[15:0];
      end
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a word-addressed memory: one request per
// transaction, sub-word stores done as read-modify-write, misaligned requests rejected.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  lsu_state_e            state_q, state_d;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            addr_lo_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] merge_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  req_mis;
  logic [31:0]           load_data;
  logic [31:0]           store_data;

  assign req_mis = is_misaligned(req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_lo_q),
    .rd_word    (mem_rd_data),
    .merge_word (merge_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_mis ? StDone : StAccess;
      end
      StAccess: begin
        if (we_q && funct3_q == F3_W) begin
          mem_wr_en   = 1'b1;
          mem_wr_data = wdata_q;
          state_d     = StDone;
        end else if (we_q) begin
          state_d = StMergeWr;
        end else begin
          state_d = StDone;
        end
      end
      StMergeWr: begin
        mem_wr_en   = 1'b1;
        mem_wr_data = store_data;
        state_d     = StDone;
      end
      StDone: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // mem_addr only moves for requests that will really touch memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_lo_q  <= 2'b00;
      wdata_q    <= '0;
      merge_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      if (state_q == StIdle && req_valid) begin
        we_q      <= req_we;
        funct3_q  <= req_funct3;
        addr_lo_q <= req_addr[1:0];
        wdata_q   <= req_wdata;
        err_q     <= req_mis;
        rdata_q   <= '0;
        if (!req_mis) mem_addr_q <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
      end
      if (state_q == StAccess) begin
        if (!we_q) rdata_q <= load_data;
        else       merge_q <= mem_rd_data;
      end
    end
  end

  assign mem_addr   = mem_addr_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural word memory and a write monitor.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  bit [31:0] mem [256];
  int        wr_cnt = 0;
  int        cyc = 0;
  int        wr_cyc = 0;
  logic [31:0] wr_addr_seen = '0;
  logic [31:0] wr_data_seen = '0;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_addr    (mem_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  assign mem_rd_data = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr_en) begin
      mem[mem_addr[9:2]] <= mem_wr_data;
      wr_cnt       <= wr_cnt + 1;
      wr_cyc       <= cyc;
      wr_addr_seen <= mem_addr;
      wr_data_seen <= mem_wr_data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  // Issues one request, waits (bounded) for resp_valid, and completes the handshake
  // when resp_ready is high. lat counts cycles from the accept edge.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                        output logic err, output int acc);
    @(negedge clk);
    check_eq("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    acc       = cyc - 1;
    req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 10);
    if (!resp_valid) check_eq("resp_timeout", 32'd0, 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
    if (resp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lat;
    int acc;
    int w0;
    logic [31:0] rd;
    logic [31:0] hold;
    logic er;

    #2;
    check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("rst_wr_en", {31'b0, mem_wr_en}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'd0);
    check_eq("rst_err", {31'b0, resp_err}, 32'd0);
    check_eq("rst_wr_data", mem_wr_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", {31'b0, req_ready}, 32'd1);

    // SW then LW
    w0 = wr_cnt;
    do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, lat, rd, er, acc);
    check_eq("sw_lat", lat, 2);
    check_eq("sw_rdata", rd, 32'd0);
    check_eq("sw_err", {31'b0, er}, 32'd0);
    check_eq("sw_wr_cnt", wr_cnt - w0, 1);
    check_eq("sw_wr_addr", wr_addr_seen, 32'h100);
    check_eq("sw_wr_data", wr_data_seen, 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h100, 32'h0, lat, rd, er, acc);
    check_eq("lw_lat", lat, 2);
    check_eq("lw_rdata", rd, 32'hDEADBEEF);
    check_eq("lw_err", {31'b0, er}, 32'd0);

    // Byte read-modify-write
    do_req(1'b1, 3'b010, 32'h104, 32'h11223344, lat, rd, er, acc);
    w0 = wr_cnt;
    do_req(1'b1, 3'b000, 32'h106, 32'hFFFFFFAA, lat, rd, er, acc);
    check_eq("sb_lat", lat, 3);
    check_eq("sb_wr_cnt", wr_cnt - w0, 1);
    check_eq("sb_wr_data", wr_data_seen, 32'h11AA3344);
    check_eq("sb_wr_addr", wr_addr_seen, 32'h104);
    check_eq("sb_wr_time", wr_cyc - acc, 2);
    check_eq("sb_mem", mem[65], 32'h11AA3344);
    do_req(1'b0, 3'b000, 32'h106, 32'h0, lat, rd, er, acc);
    check_eq("lb_rdata", rd, 32'hFFFFFFAA);
    do_req(1'b0, 3'b100, 32'h106, 32'h0, lat, rd, er, acc);
    check_eq("lbu_rdata", rd, 32'h000000AA);
    do_req(1'b0, 3'b000, 32'h104, 32'h0, lat, rd, er, acc);
    check_eq("lb_pos", rd, 32'h00000044);

    // Halfword
    w0 = wr_cnt;
    do_req(1'b1, 3'b001, 32'h10A, 32'h12348001, lat, rd, er, acc);
    check_eq("sh_lat", lat, 3);
    check_eq("sh_wr_data", wr_data_seen, 32'h80010000);
    check_eq("sh_wr_cnt", wr_cnt - w0, 1);
    do_req(1'b0, 3'b001, 32'h10A, 32'h0, lat, rd, er, acc);
    check_eq("lh_rdata", rd, 32'hFFFF8001);
    do_req(1'b0, 3'b101, 32'h10A, 32'h0, lat, rd, er, acc);
    check_eq("lhu_rdata", rd, 32'h00008001);
    do_req(1'b0, 3'b001, 32'h108, 32'h0, lat, rd, er, acc);
    check_eq("lh_low", rd, 32'h00000000);

    // Misaligned and undefined codes
    w0 = wr_cnt;
    do_req(1'b0, 3'b010, 32'h101, 32'h0, lat, rd, er, acc);
    check_eq("mis_lw_lat", lat, 1);
    check_eq("mis_lw_err", {31'b0, er}, 32'd1);
    check_eq("mis_lw_rdata", rd, 32'd0);
    do_req(1'b1, 3'b001, 32'h103, 32'h5555, lat, rd, er, acc);
    check_eq("mis_sh_lat", lat, 1);
    check_eq("mis_sh_err", {31'b0, er}, 32'd1);
    do_req(1'b1, 3'b011, 32'h100, 32'h0, lat, rd, er, acc);
    check_eq("undef_err", {31'b0, er}, 32'd1);
    check_eq("mis_no_write", wr_cnt - w0, 0);
    check_eq("mis_mem100", mem[64], 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h100, 32'h0, lat, rd, er, acc);
    check_eq("post_mis_err", {31'b0, er}, 32'd0);

    // Backpressure: response must hold and a second request must wait
    resp_ready = 1'b0;
    w0 = wr_cnt;
    do_req(1'b0, 3'b010, 32'h104, 32'h0, lat, rd, er, acc);
    check_eq("bp_rdata", rd, 32'h11AA3344);
    hold = rd;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h10C;
    req_wdata  = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_valid", {31'b0, resp_valid}, 32'd1);
      check_eq("bp_hold", resp_rdata, hold);
      check_eq("bp_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_released", {31'b0, resp_valid}, 32'd0);
    check_eq("bp_no_write", wr_cnt - w0, 0);
    check_eq("bp_mem10c", mem[67], 32'd0);

    // Reset while in MERGE_WR
    w0 = wr_cnt;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h104;
    req_wdata  = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mrg_wr_en", {31'b0, mem_wr_en}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_wr_en", {31'b0, mem_wr_en}, 32'd0);
    check_eq("rst_mid_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst_mid_no_wr", wr_cnt - w0, 0);
    check_eq("rst_mid_mem", mem[65], 32'h11AA3344);
    repeat (3) @(negedge clk);
    check_eq("rst_mid_late", wr_cnt - w0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
